// File: rtl/bcd_scan_display.sv
// Time-multiplexed common-anode 7-segment driver with per-slot blanking and leading-zero
// suppression. Define BCD_SCAN_DISPLAY_DP_EN to add per-digit decimal-point support.
module bcd_scan_display #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLANK_CYC  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [0:6]              display
`ifdef BCD_SCAN_DISPLAY_DP_EN
  ,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp
`endif
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);

  function automatic logic [0:6] seg_decode(input logic [3:0] d);
    logic [0:6] seg;
    case (d)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b1100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0001100;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d, sel_act;
  logic [0:6]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   keep;
  logic                    above, slot_end, blank_phase, cur_keep;
  logic [3:0]              cur_digit;

`ifdef BCD_SCAN_DISPLAY_DP_EN
  logic [NUM_DIGITS-1:0] dp_shadow_q, dp_shadow_d;
  logic                  dp_q, dp_d, cur_dp;
`endif

  always_comb begin
    slot_end = (cnt_q == CntMax);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
    shadow_d = load ? bcd_in : shadow_q;
`ifdef BCD_SCAN_DISPLAY_DP_EN
    dp_shadow_d = load ? dp_in : dp_shadow_q;
`endif

    // Walk from the most significant digit down; once any nonzero (or dp-marked) digit is
    // seen, every digit at or below it is kept.
    keep  = '0;
    above = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      above = above | (shadow_q[4*k +: 4] != 4'd0);
`ifdef BCD_SCAN_DISPLAY_DP_EN
      above = above | dp_shadow_q[k];
`endif
      keep[k] = above | (k == 0) | ~lz_blank;
    end

    cur_digit = '0;
    cur_keep  = 1'b0;
    sel_act   = '1;
`ifdef BCD_SCAN_DISPLAY_DP_EN
    cur_dp    = 1'b0;
`endif
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IdxW'(k)) begin
        cur_digit  = shadow_q[4*k +: 4];
        cur_keep   = keep[k];
        sel_act[k] = 1'b0;
`ifdef BCD_SCAN_DISPLAY_DP_EN
        cur_dp     = dp_shadow_q[k];
`endif
      end
    end

    blank_phase = (32'(cnt_q) < BLANK_CYC);
    sel_d       = blank_phase ? '1 : sel_act;
    // Suppressed digits keep their anode on so every slot draws the same duty cycle.
    seg_d       = (blank_phase || !cur_keep) ? 7'b1111111 : seg_decode(cur_digit);
`ifdef BCD_SCAN_DISPLAY_DP_EN
    dp_d        = blank_phase ? 1'b1 : ~cur_dp;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      sel_q       <= '1;
      seg_q       <= 7'b1111111;
`ifdef BCD_SCAN_DISPLAY_DP_EN
      dp_shadow_q <= '0;
      dp_q        <= 1'b1;
`endif
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
`ifdef BCD_SCAN_DISPLAY_DP_EN
      dp_shadow_q <= dp_shadow_d;
      dp_q        <= dp_d;
`endif
    end
  end

  assign digit_sel = sel_q;
  assign display   = seg_q;
`ifdef BCD_SCAN_DISPLAY_DP_EN
  assign dp        = dp_q;
`endif

endmodule
